relu_requant_stream: RTL and testbench
======================================

Name: relu_requant_stream

Overview:
- Sits directly downstream of the bit-serial MAC engine and consumes its stream of wide signed hidden-layer accumulators.
- Applies rounding arithmetic right shift, optional ReLU, and saturation to DATA_W per element.
- Emits an AXI-Stream-style output with TLAST on the last hidden element of each vector.
- Has a 2-stage valid/ready pipeline with full backpressure, plus per-frame saturation status.

Parameters:
- DATA_W, 16, output element width; MAC operand width.
- N_IN, 128, MAC input-vector length; sets accumulator width.
- N_HIDDEN, 64, elements per frame; TLAST on element N_HIDDEN-1.
- ACC_W, 2*DATA_W+$clog2(max(N_IN,2)), input accumulator width (derived, localparam).
- SHIFT_W, $clog2(ACC_W), width of the shift-amount port (derived, localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cfg_shift  in  SHIFT_W  right-shift amount, 0..ACC_W-1; values >= ACC_W are clamped to ACC_W-1.
- cfg_relu_en  in  1  1 = ReLU enabled.
- in_data  in  ACC_W  signed accumulator.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- m_tdata  out  DATA_W  signed result.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  last element of frame.
- sat_count  out  HID_W+1  saturated elements in current/last frame.
- frame_done  out  1  one-cycle pulse when the TLAST beat is accepted.
- busy  out  1  any pipeline stage valid, or frame counter != 0.

Behaviour:
- **Reset.** Asynchronous assert and synchronous deassert are handled externally. All of the following clear to 0: m_tvalid, m_tdata, m_tlast, sat_count, frame_done, busy, stage valids, frame counter, latched config.
- **Config latch.** cfg_shift and cfg_relu_en are latched on acceptance of a frame's first beat (frame counter == 0). They are held for the whole frame; mid-frame changes are ignored.
- **Stage 1 (round + shift).**
  - Sign-extend to ACC_W+1.
  - If shift > 0, add 1 << (shift-1) (round half up).
  - Arithmetic right shift by the latched shift.
  - Also tag the beat with last = (frame counter == N_HIDDEN-1).
- **Stage 2 (ReLU + saturate).**
  - With ReLU enabled, a negative value becomes 0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat flag = value was clipped by saturation. ReLU zeroing is not saturation.
- **Handshakes.**
  - Stage 2 loads when !s2_valid || m_tready.
  - Stage 1 loads when !s1_valid || s2 loads.
  - in_ready = s1 loads (combinational chain; no combinational path from in_valid to in_ready).
- **Latency and throughput.** 2 cycles from in accept to m_tvalid with no stall. Sustains 1 element/cycle.
- **Output stability.** m_tdata and m_tlast are stable while m_tvalid && !m_tready.
- **Frame counter (HID_W+1 bits).**
  - Increments on each input accept.
  - Wraps to 0 after N_HIDDEN-1 is accepted.
  - A new frame may enter stage 1 while the previous frame's tail drains.
- **sat_count.**
  - Increments on output accept of a saturated beat and saturates at its max.
  - Holds its value after frame_done.
  - Is cleared on output accept of the first beat of the next frame; that beat's own sat flag is then counted (count becomes sat).
- **frame_done.** Registered; asserts in the cycle after m_tvalid && m_tready && m_tlast.
- **Reset mid-frame.** The frame is discarded: no TLAST is emitted and the counter restarts at 0.
- **Simultaneous events.** Input and output accepts in the same cycle are both processed; the pipeline keeps full occupancy.

Decomposition:
- Package nn_stream_pkg:
  - acc_width and clog2-safe helper functions;
  - typedef for the output beat struct {data, last, sat}.
- Sub-module requant_core: pure combinational round/shift/ReLU/saturate. It is reused by the verification reference model and by the stage registers here.

Test Plan:
- **Round/shift:** DATA_W=16, shift=4, relu=1; in 0x1234, 0x18, 0x17 -> out 0x0123, 0x0002, 0x0001; sat_count=0.
- **ReLU and saturation:**
  - relu=1, shift=0; in -100, 2^20 -> out 0, 32767; sat_count=1 after frame.
  - relu=0; in -2^20 -> -32768.
- **Frame/TLAST:** 64 consecutive beats with m_tready=1 -> m_tlast only on beat 64; frame_done pulses once, one cycle after that accept. A second frame follows back-to-back with no bubble.
- **Backpressure:**
  - m_tready held low for 5 cycles after the first output -> in_ready drops after 2 beats are buffered; m_tdata stays stable.
  - Releasing m_tready drains all beats in order, with no loss or duplication.
- **Config latch:** cfg_shift changed from 4 to 8 at beat 10 -> beats 10..63 still use shift 4; the next frame uses 8.
- **Reset mid-frame:** rst_n low at beat 30 -> all outputs 0 immediately (asynchronous). The next frame's TLAST lands on its 64th beat.

Source files
------------

// File: rtl/nn_stream_pkg.sv
// Shared sizing helpers and beat tag type for the hidden-layer output stream.
package nn_stream_pkg;

   // $clog2 that never returns 0, so a 1-deep dimension still gets a 1-bit field
   function automatic int unsigned clog2_safe(input int unsigned v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

   // Accumulator width produced by the MAC engine for DATA_W operands over N_IN terms
   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned n_in);
      return 2 * data_w + clog2_safe(n_in);
   endfunction

   // Side-band carried with every output element; the data field is added by the
   // instantiating module because its width is a module parameter
   typedef struct packed {
      logic last;
      logic sat;
   } beat_tag_t;

endpackage

// File: rtl/requant_core.sv
// Pure combinational requantisation datapath.
// The round/shift half and the ReLU/saturate half are independent so that a
// pipeline can register between them while a reference model chains them.
module requant_core
   import nn_stream_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ACC_W   = 39,
   parameter int unsigned SHIFT_W = 6
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic        [SHIFT_W-1:0] shift,
   output logic signed [ACC_W:0]    shifted,
   input  logic signed [ACC_W:0]    sat_in,
   input  logic                     relu_en,
   output logic signed [DATA_W-1:0] data,
   output logic                     sat
);

   localparam logic signed [ACC_W:0] RND_ONE = (ACC_W+1)'(1);
   localparam logic signed [ACC_W:0] MAX_V =
      {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_V =
      {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [ACC_W:0]   ext;
   logic signed [ACC_W:0]   rnd;
   logic        [SHIFT_W-1:0] shift_m1;
   logic signed [ACC_W:0]   relu_v;

   // One extra bit of headroom keeps the rounding add from overflowing
   always_comb begin
      ext      = {acc[ACC_W-1], acc};
      shift_m1 = shift - SHIFT_W'(1);
      rnd      = '0;
      if (shift != '0) begin
         rnd = RND_ONE <<< shift_m1;
      end
      shifted = (ext + rnd) >>> shift;
   end

   // ReLU first, then clip; zeroing by ReLU never counts as saturation
   always_comb begin
      relu_v = sat_in;
      if (relu_en && sat_in[ACC_W]) begin
         relu_v = '0;
      end
      sat  = 1'b0;
      data = relu_v[DATA_W-1:0];
      if (relu_v > MAX_V) begin
         data = MAX_V[DATA_W-1:0];
         sat  = 1'b1;
      end else if (relu_v < MIN_V) begin
         data = MIN_V[DATA_W-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/relu_requant_stream.sv
// Requantises the MAC engine's accumulator stream to DATA_W through a
// two-stage valid/ready pipeline, tags frame boundaries with TLAST and keeps a
// per-frame saturation count.
module relu_requant_stream
   import nn_stream_pkg::*;
#(
   parameter  int unsigned DATA_W   = 16,
   parameter  int unsigned N_IN     = 128,
   parameter  int unsigned N_HIDDEN = 64,
   localparam int unsigned ACC_W    = acc_width(DATA_W, N_IN),
   localparam int unsigned SHIFT_W  = clog2_safe(ACC_W),
   localparam int unsigned HID_W    = clog2_safe(N_HIDDEN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic        [SHIFT_W-1:0] cfg_shift,
   input  logic                     cfg_relu_en,
   input  logic signed [ACC_W-1:0]  in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     m_tlast,
   output logic        [HID_W:0]    sat_count,
   output logic                     frame_done,
   output logic                     busy
);

   typedef struct packed {
      logic signed [DATA_W-1:0] data;
      beat_tag_t                tag;
   } out_beat_t;

   localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(ACC_W - 1);
   localparam logic [HID_W:0]     CNT_LAST  = (HID_W+1)'(N_HIDDEN - 1);
   localparam logic [HID_W:0]     CNT_ONE   = (HID_W+1)'(1);

   // Frame position and configuration held for the frame in progress
   logic [HID_W:0]       frame_cnt;
   logic [SHIFT_W-1:0]   shift_q;
   logic                 relu_q;

   // Stage 1: rounded and shifted value plus the beat's frame context
   logic                 s1_valid;
   logic signed [ACC_W:0] s1_val;
   logic                 s1_last;
   logic                 s1_relu;

   // Stage 2 side-band (data/last/valid live directly in the output ports)
   logic                 s2_sat;
   logic                 next_is_first;

   logic                 s1_load;
   logic                 s2_load;
   logic                 in_acc;
   logic                 out_acc;
   logic                 first_beat;
   logic [SHIFT_W-1:0]   shift_clamped;
   logic [SHIFT_W-1:0]   eff_shift;
   logic                 eff_relu;
   logic signed [ACC_W:0] s1_next;
   out_beat_t            s2_next;

   // Handshake chain: ready flows back from the output only, never from in_valid
   always_comb begin
      s2_load  = !m_tvalid || m_tready;
      s1_load  = !s1_valid || s2_load;
      in_acc   = in_valid && s1_load;
      out_acc  = m_tvalid && m_tready;
   end

   assign in_ready = s1_load;
   assign busy     = m_tvalid || s1_valid || (frame_cnt != '0);

   // The first beat of a frame uses the live config; later beats use the latched copy
   always_comb begin
      first_beat    = (frame_cnt == '0);
      shift_clamped = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
      eff_shift     = first_beat ? shift_clamped : shift_q;
      eff_relu      = first_beat ? cfg_relu_en : relu_q;
   end

   requant_core #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .SHIFT_W (SHIFT_W)
   ) u_core (
      .acc     (in_data),
      .shift   (eff_shift),
      .shifted (s1_next),
      .sat_in  (s1_val),
      .relu_en (s1_relu),
      .data    (s2_next.data),
      .sat     (s2_next.tag.sat)
   );

   assign s2_next.tag.last = s1_last;

   // Frame counter and per-frame configuration latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
      end else if (in_acc) begin
         if (first_beat) begin
            shift_q <= shift_clamped;
            relu_q  <= cfg_relu_en;
         end
         frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_ONE;
      end
   end

   // Stage 1 register: round + shift result, tagged with last and the frame's ReLU mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_val   <= '0;
         s1_last  <= 1'b0;
         s1_relu  <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_val  <= s1_next;
            s1_last <= (frame_cnt == CNT_LAST);
            s1_relu <= eff_relu;
         end
      end
   end

   // Stage 2 register drives the output directly so data/last hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
         s2_sat   <= 1'b0;
      end else if (s2_load) begin
         m_tvalid <= s1_valid;
         if (s1_valid) begin
            m_tdata <= s2_next.data;
            m_tlast <= s2_next.tag.last;
            s2_sat  <= s2_next.tag.sat;
         end
      end
   end

   // Saturation count restarts with the first accepted beat of each frame,
   // so the previous frame's total stays readable after frame_done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count     <= '0;
         frame_done    <= 1'b0;
         next_is_first <= 1'b1;
      end else begin
         frame_done <= out_acc && m_tlast;
         if (out_acc) begin
            next_is_first <= m_tlast;
            if (next_is_first) begin
               sat_count <= (HID_W+1)'(s2_sat);
            end else if (s2_sat && (sat_count != '1)) begin
               sat_count <= sat_count + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_relu_requant_stream.sv
// Scoreboard bench for relu_requant_stream: the driver queues hand-computed
// expected beats on input accept, a monitor pops them on output accept.
module tb_relu_requant_stream;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned N_IN     = 128;
   localparam int unsigned N_HIDDEN = 64;
   localparam int unsigned ACC_W    = 39;
   localparam int unsigned SHIFT_W  = 6;
   localparam int unsigned CNT_W    = 7;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic        [SHIFT_W-1:0] cfg_shift;
   logic                     cfg_relu_en;
   logic signed [ACC_W-1:0]  in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] m_tdata;
   logic                     m_tvalid;
   logic                     m_tready;
   logic                     m_tlast;
   logic        [CNT_W-1:0]  sat_count;
   logic                     frame_done;
   logic                     busy;

   int checks = 0;
   int failures = 0;
   int stalls = 0;
   int frames_done = 0;
   logic bp_arm = 1'b0;
   logic bp_done = 1'b0;

   logic [DATA_W:0] exp_q[$];   // {data, last}
   int              sat_q[$];

   always #5 clk = ~clk;

   relu_requant_stream #(
      .DATA_W   (DATA_W),
      .N_IN     (N_IN),
      .N_HIDDEN (N_HIDDEN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_shift   (cfg_shift),
      .cfg_relu_en (cfg_relu_en),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tlast     (m_tlast),
      .sat_count   (sat_count),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Present one beat; queue its expected output once it is accepted
   task automatic send(input longint d, input int sh, input logic relu,
                       input int e, input logic el);
      int unsigned n;
      n = 0;
      in_data     = ACC_W'(d);
      cfg_shift   = SHIFT_W'(sh);
      cfg_relu_en = relu;
      in_valid    = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
      end else begin
         exp_q.push_back({DATA_W'(e), el});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         n++;
         @(negedge clk);
      end
      if (exp_q.size() != 0 || busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: pending=%0d busy=%0d", exp_q.size(), busy);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every accepted output beat and frame_done/sat_count
   initial begin
      logic fd_pend;
      logic [DATA_W:0] e;
      fd_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            fd_pend = 1'b0;
            continue;
         end
         check("frame_done", frame_done, fd_pend);
         if (frame_done) begin
            frames_done++;
            if (sat_q.size() != 0) begin
               check("sat_count", sat_count, sat_q.pop_front());
            end else begin
               checks++;
               failures++;
               $display("FAIL extra_frame_done: got frame_done expected none");
            end
         end
         fd_pend = m_tvalid && m_tready && m_tlast;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got data %0d with nothing expected", m_tdata);
            end else begin
               e = exp_q.pop_front();
               check("tdata", m_tdata, $signed(e[DATA_W:1]));
               check("tlast", m_tlast, e[0]);
            end
         end
      end
   end

   // Output-side backpressure: hold m_tready low for 5 cycles after the first output
   initial begin
      int unsigned n;
      m_tready = 1'b1;
      wait (bp_arm);
      n = 0;
      @(negedge clk);
      while (!m_tvalid && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!m_tvalid) begin
         checks++;
         failures++;
         $display("FAIL bp_no_output: got m_tvalid 0 expected 1");
      end
      @(posedge clk);
      #1;
      m_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_tvalid", m_tvalid, 1);
         check("bp_tdata", m_tdata, 1);
         check("bp_tlast", m_tlast, 0);
         check("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      bp_done  = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      cfg_shift   = '0;
      cfg_relu_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_sat_count", sat_count, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Frame 1: rounding with shift 4
      sat_q.push_back(0);
      send(64'sh1234, 4, 1'b1, 16'h0123, 1'b0);
      send(64'sh18,   4, 1'b1, 2, 1'b0);
      send(64'sh17,   4, 1'b1, 1, 1'b0);
      for (int i = 3; i < 64; i++) send(longint'(i) * 16, 4, 1'b1, i, i == 63);

      // Frame 2: ReLU zeroing and positive saturation, back to back
      sat_q.push_back(1);
      send(-100, 0, 1'b1, 0, 1'b0);
      send(longint'(1) << 20, 0, 1'b1, 32767, 1'b0);
      for (int i = 2; i < 64; i++) send(i, 0, 1'b1, i, i == 63);

      // Frame 3: ReLU off, both saturation boundaries
      sat_q.push_back(3);
      send(-(longint'(1) << 20), 0, 1'b0, -32768, 1'b0);
      send(32767,  0, 1'b0, 32767, 1'b0);
      send(32768,  0, 1'b0, 32767, 1'b0);
      send(-32768, 0, 1'b0, -32768, 1'b0);
      send(-32769, 0, 1'b0, -32768, 1'b0);
      for (int i = 5; i < 64; i++) send(-i, 0, 1'b0, -i, i == 63);
      check("no_bubble", stalls, 0);
      wait_idle();

      // Frame 4: downstream stall
      sat_q.push_back(0);
      bp_arm = 1'b1;
      for (int i = 0; i < 64; i++) send(longint'(i) * 16, 4, 1'b1, i, i == 63);
      wait_idle();
      check("bp_ran", bp_done, 1);

      // Frame 5: shift changed mid-frame is ignored; frame 6 picks it up
      sat_q.push_back(0);
      for (int i = 0; i < 64; i++) send(longint'(i) * 16, (i < 10) ? 4 : 8, 1'b1, i, i == 63);
      sat_q.push_back(0);
      for (int i = 0; i < 64; i++) send(longint'(i) * 256, 8, 1'b1, i, i == 63);

      // Frame 7: out-of-range shift clamps to ACC_W-1 = 38
      sat_q.push_back(0);
      send((longint'(1) << 38) - 1, 63, 1'b0, 1, 1'b0);
      send(-(longint'(1) << 38),    63, 1'b0, -1, 1'b0);
      for (int i = 2; i < 64; i++) send(longint'(i) << 32, 63, 1'b0, (i + 32) / 64, i == 63);
      wait_idle();

      // Frame 8: reset at beat 30 discards the frame
      for (int i = 0; i < 30; i++) send(i, 0, 1'b1, i, 1'b0);
      in_data  = ACC_W'(30);
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", m_tvalid, 0);
      check("mid_rst_tdata", m_tdata, 0);
      check("mid_rst_tlast", m_tlast, 0);
      check("mid_rst_sat_count", sat_count, 0);
      check("mid_rst_frame_done", frame_done, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      in_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Frame 9: counter restarted, TLAST on beat 64; one saturated beat
      sat_q.push_back(1);
      for (int i = 0; i < 64; i++) begin
         if (i == 5) send(longint'(1) << 24, 4, 1'b1, 32767, 1'b0);
         else        send(longint'(i) * 16 + 7, 4, 1'b1, i, i == 63);
      end
      wait_idle();
      repeat (3) @(negedge clk);
      check("sat_count_hold", sat_count, 1);
      check("final_busy", busy, 0);
      check("frames_done", frames_done, 8);
      check("sb_drained", exp_q.size(), 0);
      check("sat_q_drained", sat_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
